c10_pattern_gen: RTL and testbench
==================================

# c10_pattern_gen

Upstream stimulus stage for the C10Fritz benchmark cone. It drives the eight primary inputs G1gat–G8gat with a sequence of test patterns under a valid/ready handshake, so the downstream capture stage can sample G9gat once per accepted pattern. Patterns come from an exhaustive binary counter or, when compiled in, an 8-bit maximal-length LFSR. A start/busy/done control interface frames each run of NPAT patterns.

## Interface
- SEED, 8'h01, first pattern of a run
- NPAT, 256, patterns per run; legal range 1..256
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  begin a run; sampled only in IDLE
- mode  in  1  0 = counter, 1 = LFSR (see Configuration)
- ready  in  1  downstream accepts current pattern this cycle
- valid  out  1  G1gat..G8gat hold a pattern to be consumed
- G1gat..G8gat  out  1 each  pattern bits; G1gat = pat[0] … G8gat = pat[7]
- pat_idx  out  8  index of current pattern within run, 0..NPAT-1
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse after last pattern accepted

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start=1 → load pat=SEED, pat_idx=0, latch mode into run_mode, go RUN. Otherwise hold.
- RUN: valid=1. Handshake = valid & ready.
  - Handshake with pat_idx < NPAT-1 → pat = next(pat), pat_idx+1.
  - Handshake with pat_idx = NPAT-1 → go DONE; pat and pat_idx hold.
  - No handshake → pat, pat_idx hold (stable under backpressure).
- DONE: valid=0, done=1 for exactly one cycle → IDLE.
- next(pat), counter: pat+1 mod 256 (FF → 00 wraps silently).
- next(pat), LFSR: Fibonacci, {pat[6:0], pat[7]^pat[5]^pat[4]^pat[3]} (x^8+x^6+x^5+x^4+1).
- LFSR lock-up: SEED=0 in LFSR mode loads 8'h01 instead.
- Run counter is internally 9 bits so NPAT=256 terminates correctly.
- start while busy: ignored. mode changes mid-run: ignored (run_mode latched).
- ready while valid=0: no effect.

## Timing
- Reset values: valid=0, done=0, busy=0, G1gat..G8gat=0, pat_idx=0, state IDLE.
- start high at edge t (IDLE) → valid=1, pattern=SEED, busy=1 after edge t.
- Each handshake at edge t → next pattern visible after edge t; one pattern per cycle at ready=1.
- Final handshake at edge t → after t: valid=0, done=1; after t+1: done=0, busy=0, IDLE. start accepted at t+2 earliest.
- All outputs registered; no combinational path from ready/start to any output.
- rst_n low at any point, including mid-run or in DONE: immediately returns all outputs to reset values; no done pulse produced.

## Configuration
- C10_PATGEN_LFSR_EN defined: LFSR generator present; mode selects counter (0) or LFSR (1).
- Not defined: LFSR logic absent; mode input ignored, always counter; SEED=0 substitution absent.

## Test plan
- Counter, SEED=8'h10, NPAT=4, ready=1, start pulse → patterns 10,11,12,13 on consecutive cycles, pat_idx 0..3, done one cycle after 13 accepted, busy drops next cycle.
- Wrap: SEED=8'hFE, NPAT=4 → FE,FF,00,01; done once.
- Backpressure: NPAT=3, ready=0 for 5 cycles after valid rises → pattern and pat_idx held stable; resume ready=1 → remaining patterns in order, no skips or repeats.
- LFSR (C10_PATGEN_LFSR_EN, mode=1), SEED=8'h01, NPAT=5 → 01,02,04,08,11; SEED=0 → first pattern 01.
- Control corners: start held high throughout and mode toggled mid-run → single run, sequence unchanged; start re-accepted only after busy=0.
- Reset mid-run: rst_n low during pattern 2 of 4 → valid, busy, done, G*gat, pat_idx all 0 asynchronously; new start after release restarts at SEED.

Source files
------------

// File: rtl/c10_pattern_gen.sv
// Pattern source for the C10Fritz cone: drives G1gat..G8gat under a valid/ready handshake.
// Define C10_PATGEN_LFSR_EN to build in the 8-bit LFSR generator, selected at start by mode.
//
// state  | meaning
// IDLE   | waiting for start, outputs quiet
// RUN    | valid pattern presented, advances on each accepted handshake
// DONE   | one-cycle done pulse after the last pattern was accepted
module c10_pattern_gen #(
    parameter logic [7:0] SEED = 8'h01,
    parameter int         NPAT = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic       ready,
    output logic       valid,
    output logic       G1gat,
    output logic       G2gat,
    output logic       G3gat,
    output logic       G4gat,
    output logic       G5gat,
    output logic       G6gat,
    output logic       G7gat,
    output logic       G8gat,
    output logic [7:0] pat_idx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Nine bits so the final index of a 256-pattern run compares cleanly.
    localparam logic [8:0] LAST_IDX = 9'(NPAT - 1);

    state_t     state_q, state_d;
    logic [7:0] pat_q, pat_d;
    logic [8:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] next_pat;
    logic [7:0] seed_load;

`ifdef C10_PATGEN_LFSR_EN
    logic run_mode_q, run_mode_d;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1; an all-zero seed would lock the LFSR.
    assign next_pat  = run_mode_q ? {pat_q[6:0], pat_q[7] ^ pat_q[5] ^ pat_q[4] ^ pat_q[3]}
                                  : pat_q + 8'd1;
    assign seed_load = (mode && (SEED == 8'h00)) ? 8'h01 : SEED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_mode_q <= 1'b0;
        else        run_mode_q <= run_mode_d;
    end

    always_comb begin
        run_mode_d = run_mode_q;
        if (state_q == S_IDLE && start) run_mode_d = mode;
    end
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign next_pat    = pat_q + 8'd1;
    assign seed_load   = SEED;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pat_q   <= 8'h00;
            cnt_q   <= 9'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    pat_d   = seed_load;
                    cnt_d   = 9'd0;
                end
            end
            S_RUN: begin
                if (ready) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        pat_d = next_pat;
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        valid_d = (state_d == S_RUN);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    assign valid   = valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pat_idx = cnt_q[7:0];
    assign G1gat   = pat_q[0];
    assign G2gat   = pat_q[1];
    assign G3gat   = pat_q[2];
    assign G4gat   = pat_q[3];
    assign G5gat   = pat_q[4];
    assign G6gat   = pat_q[5];
    assign G7gat   = pat_q[6];
    assign G8gat   = pat_q[7];

endmodule

// File: tb/tb_c10_pattern_gen.sv
// Bench for c10_pattern_gen: several instances with different SEED/NPAT, a vector table of runs
// with randomized ready/mode, and hand sequences for reset and restart corners.
module tb_c10_pattern_gen;

    localparam int N = 5;
    localparam logic [7:0] SEEDS [N] = '{8'h10, 8'hFE, 8'h01, 8'h00, 8'h5A};
    localparam int         NPATS [N] = '{4, 4, 3, 5, 256};

    logic clk;
    logic rst_n;
    logic start_s [N];
    logic mode_s  [N];
    logic ready_s [N];
    wire        valid_w [N];
    wire        busy_w  [N];
    wire        done_w  [N];
    wire  [7:0] pat_w   [N];
    wire  [7:0] idx_w   [N];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        c10_pattern_gen #(.SEED(SEEDS[g]), .NPAT(NPATS[g])) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start_s[g]),
            .mode   (mode_s[g]),
            .ready  (ready_s[g]),
            .valid  (valid_w[g]),
            .G1gat  (pat_w[g][0]),
            .G2gat  (pat_w[g][1]),
            .G3gat  (pat_w[g][2]),
            .G4gat  (pat_w[g][3]),
            .G5gat  (pat_w[g][4]),
            .G6gat  (pat_w[g][5]),
            .G7gat  (pat_w[g][6]),
            .G8gat  (pat_w[g][7]),
            .pat_idx(idx_w[g]),
            .busy   (busy_w[g]),
            .done   (done_w[g])
        );
    end

    typedef struct {
        int         g;
        bit         m;
        int         pct;
        bit         hold;
        int         stall;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d t=%0t actual=%0h required=%0h", name, g, $time, act, exp);
        end
    endtask

    // Reference: k-th pattern of a run, stepping the polynomial / adding one k times.
    function automatic logic [7:0] exp_pat(input logic [7:0] seed, input bit lfsr, input int k);
        logic [7:0] p;
        p = seed;
        if (lfsr && p == 8'h00) p = 8'h01;
        for (int i = 0; i < k; i++) begin
            if (lfsr) p = (p << 1) | {7'd0, ^(p & 8'hB8)};
            else      p = p + 8'd1;
        end
        return p;
    endfunction

    function automatic bit eff_mode(input bit m);
`ifdef C10_PATGEN_LFSR_EN
        return m;
`else
        return 1'b0 & m;
`endif
    endfunction

    task automatic check_quiet(input string name, input int g);
        chk({name, "_valid"}, g, valid_w[g], 0);
        chk({name, "_busy"},  g, busy_w[g], 0);
        chk({name, "_done"},  g, done_w[g], 0);
        chk({name, "_pat"},   g, pat_w[g], 0);
        chk({name, "_idx"},   g, idx_w[g], 0);
    endtask

    // Entered and left on a negedge with the instance idle.
    task automatic run(input vec_t v);
        int         g, k, cyc;
        bit         fin, em;
        logic [7:0] lastpat;
        g  = v.g;
        em = eff_mode(v.m);
        lastpat = 8'hxx;
        start_s[g] = 1'b1;
        mode_s[g]  = v.m;
        ready_s[g] = 1'b0;
        @(posedge clk); @(negedge clk);
        if (!v.hold) start_s[g] = 1'b0;
        chk("busy_on", g, busy_w[g], 1);
        chk("first_pat", g, pat_w[g], v.exp_first);
        k = 0; fin = 0; cyc = 0;
        while (!fin && cyc < 3000) begin
            chk("valid", g, valid_w[g], 1);
            chk("pat", g, pat_w[g], exp_pat(SEEDS[g], em, k));
            chk("idx", g, idx_w[g], k);
            chk("done_lo", g, done_w[g], 0);
            mode_s[g]  = 1'($urandom_range(0, 1));
            ready_s[g] = (cyc >= v.stall) && ($urandom_range(0, 99) < v.pct);
            if (ready_s[g]) begin
                lastpat = pat_w[g];
                if (k == NPATS[g] - 1) fin = 1;
                else k++;
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        if (!fin) chk("run_timeout", g, 0, 1);
        ready_s[g] = 1'($urandom_range(0, 1));
        chk("last_pat", g, lastpat, v.exp_last);
        chk("end_valid", g, valid_w[g], 0);
        chk("end_done", g, done_w[g], 1);
        chk("end_busy", g, busy_w[g], 1);
        @(posedge clk); @(negedge clk);
        chk("post_done", g, done_w[g], 0);
        chk("post_busy", g, busy_w[g], 0);
        chk("post_valid", g, valid_w[g], 0);
        if (v.hold) begin
            @(posedge clk); @(negedge clk);
            chk("restart_busy", g, busy_w[g], 1);
            chk("restart_idx", g, idx_w[g], 0);
            chk("restart_pat", g, pat_w[g], v.exp_first);
            start_s[g] = 1'b0;
            ready_s[g] = 1'b1;
            for (int i = 0; i < NPATS[g] + 5; i++) begin
                @(posedge clk); @(negedge clk);
                if (done_w[g]) break;
            end
            chk("drain_done", g, done_w[g], 1);
            @(posedge clk); @(negedge clk);
        end
        ready_s[g] = 1'b0;
        mode_s[g]  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            start_s[i] = 1'b0;
            mode_s[i]  = 1'b0;
            ready_s[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) check_quiet("reset", i);
        rst_n = 1'b1;
        @(negedge clk);

        vecs.push_back('{0, 1'b0, 100, 1'b0, 0, 8'h10, 8'h13});
        vecs.push_back('{1, 1'b0, 100, 1'b0, 0, 8'hFE, 8'h01});
        vecs.push_back('{2, 1'b0, 100, 1'b0, 5, 8'h01, 8'h03});
        vecs.push_back('{0, 1'b0, 100, 1'b1, 0, 8'h10, 8'h13});
        vecs.push_back('{3, 1'b0, 70,  1'b0, 0, 8'h00, 8'h04});
        vecs.push_back('{4, 1'b0, 60,  1'b0, 0, 8'h5A, 8'h59});
`ifdef C10_PATGEN_LFSR_EN
        vecs.push_back('{3, 1'b1, 100, 1'b0, 0, 8'h01, 8'h11});
        vecs.push_back('{2, 1'b1, 50,  1'b0, 2, 8'h01, 8'h04});
        vecs.push_back('{4, 1'b1, 60,  1'b0, 0, 8'h5A, 8'h5A});
        vecs.push_back('{0, 1'b1, 100, 1'b1, 0, 8'h10, 8'h86});
`else
        vecs.push_back('{3, 1'b1, 100, 1'b0, 0, 8'h00, 8'h04});
`endif
        foreach (vecs[i]) run(vecs[i]);

        // Reset asserted between clock edges while pattern index 2 is presented.
        start_s[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        start_s[0] = 1'b0;
        ready_s[0] = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("pre_rst_idx", 0, idx_w[0], 2);
        chk("pre_rst_pat", 0, pat_w[0], 8'h12);
        #2 rst_n = 1'b0;
        #1 check_quiet("async_rst", 0);
        ready_s[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        check_quiet("held_rst", 0);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check_quiet("rst_release", 0);
        run('{0, 1'b0, 80, 1'b0, 0, 8'h10, 8'h13});

        // Reset during the done pulse must suppress it.
        start_s[1] = 1'b1;
        @(posedge clk); @(negedge clk);
        start_s[1] = 1'b0;
        ready_s[1] = 1'b1;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        ready_s[1] = 1'b0;
        chk("done_before_rst", 1, done_w[1], 1);
        #1 rst_n = 1'b0;
        #1 check_quiet("rst_in_done", 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check_quiet("after_done_rst", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
